// File: rtl/tap_pkg.sv
// Shared TAP controller definitions: 1149.1 state encoding, DR path selector,
// instruction opcode values and the default instruction register width.
package tap_pkg;

  localparam int unsigned IR_W_DEF = 4;

  localparam int unsigned OP_IDCODE      = 1;
  localparam int unsigned OP_INSCANWRAP  = 2;
  localparam int unsigned OP_OUTSCANWRAP = 3;
  localparam int unsigned OP_WRAP_CFG    = 4;

  typedef enum logic [3:0] {
    ST_TLR,
    ST_RTI,
    ST_SEL_DR,
    ST_CAP_DR,
    ST_SH_DR,
    ST_EX1_DR,
    ST_PA_DR,
    ST_EX2_DR,
    ST_UPD_DR,
    ST_SEL_IR,
    ST_CAP_IR,
    ST_SH_IR,
    ST_EX1_IR,
    ST_PA_IR,
    ST_EX2_IR,
    ST_UPD_IR
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS,
    DR_IDCODE,
    DR_WRAP,
    DR_CFG
  } dr_sel_e;

endpackage

// File: rtl/tap_fsm.sv
// IEEE 1149.1 16-state TAP controller; advances on TMS at each rising TDR_TCK,
// synchronous active-high reset forces Test-Logic-Reset.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       TDR_TCK,
  input  logic       TDR_TRESET,
  input  logic       TMS,
  output tap_state_e state_o
);

  tap_state_e state_q;
  tap_state_e state_d;

  always_ff @(posedge TDR_TCK) begin
    if (TDR_TRESET) begin
      state_q <= ST_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:    state_d = TMS ? ST_TLR    : ST_RTI;
      ST_RTI:    state_d = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: state_d = TMS ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: state_d = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  state_d = TMS ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: state_d = TMS ? ST_UPD_DR : ST_PA_DR;
      ST_PA_DR:  state_d = TMS ? ST_EX2_DR : ST_PA_DR;
      ST_EX2_DR: state_d = TMS ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: state_d = TMS ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: state_d = TMS ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: state_d = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  state_d = TMS ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: state_d = TMS ? ST_UPD_IR : ST_PA_IR;
      ST_PA_IR:  state_d = TMS ? ST_EX2_IR : ST_PA_IR;
      ST_EX2_IR: state_d = TMS ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: state_d = TMS ? ST_SEL_DR : ST_RTI;
      default:   state_d = ST_TLR;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/tap_ctrl.sv
// JTAG TAP with IR, BYPASS, WRAP_CFG and scan-wrapper strobes/chain muxing.
// Define TAP_CTRL_IDCODE_EN to include the IDCODE register and opcode.
module tap_ctrl
  import tap_pkg::*;
#(
  parameter int unsigned IR_W       = IR_W_DEF,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0A01
) (
  input  logic TDR_TCK,
  input  logic TDR_TRESET,
  input  logic TMS,
  input  logic TDI,
  input  logic CTO,
  output logic TDO,
  output logic CTI,
  output logic TDR_CAPTURE,
  output logic TDR_SHIFT,
  output logic TDR_UPDATE,
  output logic INSCANWRAP_TDR_EN,
  output logic OUTSCANWRAP_TDR_EN,
  output logic inscanwrap_sel,
  output logic outscanwrap_sel
);

  localparam logic [IR_W-1:0] IR_BYPASS  = '1;
  localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(OP_IDCODE);
  localparam logic [IR_W-1:0] IR_INSCAN  = IR_W'(OP_INSCANWRAP);
  localparam logic [IR_W-1:0] IR_OUTSCAN = IR_W'(OP_OUTSCANWRAP);
  localparam logic [IR_W-1:0] IR_WRAPCFG = IR_W'(OP_WRAP_CFG);
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(2'b01);

`ifdef TAP_CTRL_IDCODE_EN
  localparam logic [IR_W-1:0] IR_RESET = IR_IDCODE;
  localparam logic [31:0]     IDC_CAP  = IDCODE_VAL | 32'h0000_0001;
`else
  localparam logic [IR_W-1:0] IR_RESET = IR_BYPASS;
`endif

  tap_state_e state_q;

  tap_fsm u_fsm (
    .TDR_TCK    (TDR_TCK),
    .TDR_TRESET (TDR_TRESET),
    .TMS        (TMS),
    .state_o    (state_q)
  );

  logic [IR_W-1:0] ir_sr_q, ir_sr_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            byp_q, byp_d;
  logic [1:0]      cfg_sr_q, cfg_sr_d;
  logic [1:0]      en_q, en_d;
  logic            tdo_q, tdo_d;
  dr_sel_e         dr_sel;
  logic            wrap_sel;
  logic            tlr_entry;

`ifdef TAP_CTRL_IDCODE_EN
  logic [31:0]     idc_sr_q, idc_sr_d;
`else
  logic            unused_idcode;
  assign unused_idcode = ^{IDCODE_VAL, IR_IDCODE};
`endif

  // The FSM lands in TLR on this edge, so IR/WRAP_CFG clear on the same edge.
  assign tlr_entry = TDR_TRESET |
                     (TMS & ((state_q == ST_TLR) | (state_q == ST_SEL_IR)));

  assign inscanwrap_sel  = (ir_q == IR_INSCAN);
  assign outscanwrap_sel = (ir_q == IR_OUTSCAN);
  assign wrap_sel        = inscanwrap_sel | outscanwrap_sel;

  always_comb begin
    dr_sel = DR_BYPASS;
    if (wrap_sel) begin
      dr_sel = DR_WRAP;
    end else if (ir_q == IR_WRAPCFG) begin
      dr_sel = DR_CFG;
    end
`ifdef TAP_CTRL_IDCODE_EN
    else if (ir_q == IR_IDCODE) begin
      dr_sel = DR_IDCODE;
    end
`endif
  end

  always_comb begin
    ir_sr_d = ir_sr_q;
    ir_d    = ir_q;
    case (state_q)
      ST_CAP_IR: ir_sr_d = IR_CAPTURE;
      ST_SH_IR:  ir_sr_d = {TDI, ir_sr_q[IR_W-1:1]};
      ST_UPD_IR: ir_d    = ir_sr_q;
      default: ;
    endcase
    if (tlr_entry) begin
      ir_d = IR_RESET;
    end
  end

  always_comb begin
    byp_d    = byp_q;
    cfg_sr_d = cfg_sr_q;
    en_d     = en_q;
    tdo_d    = tdo_q;
`ifdef TAP_CTRL_IDCODE_EN
    idc_sr_d = idc_sr_q;
`endif
    case (state_q)
      ST_CAP_DR: begin
        case (dr_sel)
          DR_BYPASS: byp_d    = 1'b0;
          DR_CFG:    cfg_sr_d = en_q;
`ifdef TAP_CTRL_IDCODE_EN
          DR_IDCODE: idc_sr_d = IDC_CAP;
`endif
          default: ;
        endcase
      end
      ST_SH_DR: begin
        case (dr_sel)
          DR_BYPASS: begin
            tdo_d = byp_q;
            byp_d = TDI;
          end
          DR_CFG: begin
            tdo_d    = cfg_sr_q[0];
            cfg_sr_d = {TDI, cfg_sr_q[1]};
          end
          DR_WRAP: tdo_d = CTO;
`ifdef TAP_CTRL_IDCODE_EN
          DR_IDCODE: begin
            tdo_d    = idc_sr_q[0];
            idc_sr_d = {TDI, idc_sr_q[31:1]};
          end
`endif
          default: ;
        endcase
      end
      ST_SH_IR:  tdo_d = ir_sr_q[0];
      ST_UPD_DR: begin
        if (dr_sel == DR_CFG) begin
          en_d = cfg_sr_q;
        end
      end
      default: ;
    endcase
    if (tlr_entry) begin
      en_d = '0;
    end
  end

  always_ff @(posedge TDR_TCK) begin
    if (TDR_TRESET) begin
      ir_sr_q  <= '0;
      ir_q     <= IR_RESET;
      byp_q    <= 1'b0;
      cfg_sr_q <= '0;
      en_q     <= '0;
      tdo_q    <= 1'b0;
    end else begin
      ir_sr_q  <= ir_sr_d;
      ir_q     <= ir_d;
      byp_q    <= byp_d;
      cfg_sr_q <= cfg_sr_d;
      en_q     <= en_d;
      tdo_q    <= tdo_d;
    end
  end

`ifdef TAP_CTRL_IDCODE_EN
  always_ff @(posedge TDR_TCK) begin
    if (TDR_TRESET) begin
      idc_sr_q <= '0;
    end else begin
      idc_sr_q <= idc_sr_d;
    end
  end
`endif

  assign TDO                = tdo_q;
  assign CTI                = TDI;
  assign INSCANWRAP_TDR_EN  = en_q[0];
  assign OUTSCANWRAP_TDR_EN = en_q[1];
  assign TDR_CAPTURE        = wrap_sel & (state_q == ST_CAP_DR);
  assign TDR_SHIFT          = wrap_sel & (state_q == ST_SH_DR);
  assign TDR_UPDATE         = wrap_sel & (state_q == ST_UPD_DR);

endmodule

// File: tb/tb_tap_ctrl.sv
// Directed self-checking bench for tap_ctrl: reset, IR load/capture, IDCODE or
// default BYPASS, WRAP_CFG, wrapper strobes, TMS reset, mid-shift reset, bypass.
module tb_tap_ctrl;
  import tap_pkg::*;

  logic TDR_TCK = 1'b0;
  logic TDR_TRESET, TMS, TDI, CTO;
  logic TDO, CTI, TDR_CAPTURE, TDR_SHIFT, TDR_UPDATE;
  logic INSCANWRAP_TDR_EN, OUTSCANWRAP_TDR_EN, inscanwrap_sel, outscanwrap_sel;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  tap_ctrl #(.IR_W(4), .IDCODE_VAL(32'h1000_0A01)) dut (
    .TDR_TCK            (TDR_TCK),
    .TDR_TRESET         (TDR_TRESET),
    .TMS                (TMS),
    .TDI                (TDI),
    .CTO                (CTO),
    .TDO                (TDO),
    .CTI                (CTI),
    .TDR_CAPTURE        (TDR_CAPTURE),
    .TDR_SHIFT          (TDR_SHIFT),
    .TDR_UPDATE         (TDR_UPDATE),
    .INSCANWRAP_TDR_EN  (INSCANWRAP_TDR_EN),
    .OUTSCANWRAP_TDR_EN (OUTSCANWRAP_TDR_EN),
    .inscanwrap_sel     (inscanwrap_sel),
    .outscanwrap_sel    (outscanwrap_sel)
  );

  always #5 TDR_TCK = ~TDR_TCK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TDR_TCK);
    #1;
  endtask

  // From RTI/TLR: load an opcode, return the first two IR-shift TDO bits, end in RTI.
  task automatic load_ir(input logic [3:0] op, output logic [1:0] cap);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, op[i]);
      if (i < 2) cap[i] = TDO;
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic goto_shift_dr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic finish_dr();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    TDR_TRESET = 1'b1; CTO = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    TDR_TRESET = 1'b0;
    outs = {TDO, TDR_CAPTURE, TDR_SHIFT, TDR_UPDATE, INSCANWRAP_TDR_EN,
            OUTSCANWRAP_TDR_EN, inscanwrap_sel, outscanwrap_sel};
    total_cnt++;
    if (outs !== 8'b0) $display("FAIL reset_outputs: got %b want %b", outs, 8'b0);
    else pass_cnt++;
    total_cnt++;
    if (dut.state_q !== ST_TLR) $display("FAIL reset_state: got %0d want %0d", dut.state_q, ST_TLR);
    else pass_cnt++;
    TDI = 1'b1; #1;
    total_cnt++;
    if (CTI !== 1'b1) $display("FAIL cti_hi: got %b want 1", CTI);
    else pass_cnt++;
    TDI = 1'b0; #1;
    total_cnt++;
    if (CTI !== 1'b0) $display("FAIL cti_lo: got %b want 0", CTI);
    else pass_cnt++;
  endtask

  task automatic test_default_ir();
`ifdef TAP_CTRL_IDCODE_EN
    logic [31:0] idc;
    idc = 32'h1000_0A01;
    step(1'b0, 1'b0);
    goto_shift_dr();
    for (int i = 0; i < 32; i++) begin
      step(i == 31, 1'b0);
      total_cnt++;
      if (TDO !== idc[i]) $display("FAIL idcode_bit%0d: got %b want %b", i, TDO, idc[i]);
      else pass_cnt++;
    end
    finish_dr();
`else
    logic [2:0] tdi_v, exp_v;
    logic [1:0] cap;
    tdi_v = 3'b011;
    exp_v = 3'b110;
    step(1'b0, 1'b0);
    goto_shift_dr();
    for (int i = 0; i < 3; i++) begin
      step(i == 2, tdi_v[i]);
      total_cnt++;
      if (TDO !== exp_v[i]) $display("FAIL default_bypass_bit%0d: got %b want %b", i, TDO, exp_v[i]);
      else pass_cnt++;
    end
    finish_dr();
    load_ir(4'h1, cap);
    goto_shift_dr();
    step(1'b0, 1'b1);
    total_cnt++;
    if (TDO !== 1'b0) $display("FAIL op1_bypass_cap: got %b want 0", TDO);
    else pass_cnt++;
    step(1'b1, 1'b0);
    total_cnt++;
    if (TDO !== 1'b1) $display("FAIL op1_bypass_shift: got %b want 1", TDO);
    else pass_cnt++;
    finish_dr();
`endif
  endtask

  task automatic test_ir_capture();
    logic [1:0] cap;
    load_ir(4'hF, cap);
    total_cnt++;
    if (cap !== 2'b01) $display("FAIL ir_capture: got %b want %b", cap, 2'b01);
    else pass_cnt++;
    total_cnt++;
    if ({inscanwrap_sel, outscanwrap_sel} !== 2'b00)
      $display("FAIL ir_bypass_sels: got %b want 00", {inscanwrap_sel, outscanwrap_sel});
    else pass_cnt++;
  endtask

  task automatic test_wrap_cfg();
    logic [1:0] cap;
    load_ir(4'h4, cap);
    goto_shift_dr();
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    total_cnt++;
    if ({OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN, TDR_UPDATE} !== 3'b000)
      $display("FAIL cfg_in_update: got %b want 000", {OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN, TDR_UPDATE});
    else pass_cnt++;
    step(1'b0, 1'b0);
    total_cnt++;
    if ({OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN} !== 2'b11)
      $display("FAIL cfg_after_update: got %b want 11", {OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN});
    else pass_cnt++;
    load_ir(4'hF, cap);
    total_cnt++;
    if ({OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN} !== 2'b11)
      $display("FAIL cfg_after_update_ir: got %b want 11", {OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN});
    else pass_cnt++;
    goto_shift_dr();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    finish_dr();
    total_cnt++;
    if ({OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN} !== 2'b11)
      $display("FAIL cfg_after_bypass_dr: got %b want 11", {OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN});
    else pass_cnt++;
    load_ir(4'h4, cap);
    goto_shift_dr();
    step(1'b0, 1'b0);
    total_cnt++;
    if (TDO !== 1'b1) $display("FAIL cfg_capture_b0: got %b want 1", TDO);
    else pass_cnt++;
    step(1'b1, 1'b1);
    total_cnt++;
    if (TDO !== 1'b1) $display("FAIL cfg_capture_b1: got %b want 1", TDO);
    else pass_cnt++;
    finish_dr();
    total_cnt++;
    if ({OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN} !== 2'b10)
      $display("FAIL cfg_split: got %b want 10", {OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN});
    else pass_cnt++;
  endtask

  task automatic test_wrap_strobes();
    logic [1:0] cap;
    logic [7:0] tms_v, cto_v, tdo_v;
    logic [2:0] strb [8];
    int unsigned n_cap, n_sh, n_up;
    tms_v = 8'b0110_0001;
    cto_v = 8'b0010_1100;
    tdo_v = 8'b1110_1000;
    strb = '{3'b000, 3'b100, 3'b010, 3'b010, 3'b010, 3'b000, 3'b001, 3'b000};
    n_cap = 0; n_sh = 0; n_up = 0;
    load_ir(4'h2, cap);
    total_cnt++;
    if ({inscanwrap_sel, outscanwrap_sel} !== 2'b10)
      $display("FAIL inscan_sel: got %b want 10", {inscanwrap_sel, outscanwrap_sel});
    else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      CTO = cto_v[i];
      step(tms_v[i], 1'b0);
      n_cap += TDR_CAPTURE; n_sh += TDR_SHIFT; n_up += TDR_UPDATE;
      total_cnt++;
      if ({TDR_CAPTURE, TDR_SHIFT, TDR_UPDATE} !== strb[i])
        $display("FAIL strobes_step%0d: got %b want %b", i, {TDR_CAPTURE, TDR_SHIFT, TDR_UPDATE}, strb[i]);
      else pass_cnt++;
      if (i >= 2) begin
        total_cnt++;
        if (TDO !== tdo_v[i]) $display("FAIL cto_tdo_step%0d: got %b want %b", i, TDO, tdo_v[i]);
        else pass_cnt++;
      end
    end
    CTO = 1'b0;
    total_cnt++;
    if ({n_cap, n_sh, n_up} !== {32'd1, 32'd3, 32'd1})
      $display("FAIL strobe_counts: got %0d/%0d/%0d want 1/3/1", n_cap, n_sh, n_up);
    else pass_cnt++;
  endtask

  task automatic test_tlr_by_tms();
    logic [1:0] cap;
    load_ir(4'h3, cap);
    total_cnt++;
    if ({inscanwrap_sel, outscanwrap_sel} !== 2'b01)
      $display("FAIL outscan_sel: got %b want 01", {inscanwrap_sel, outscanwrap_sel});
    else pass_cnt++;
    goto_shift_dr();
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    total_cnt++;
    if (dut.state_q !== ST_TLR) $display("FAIL tms_tlr_state: got %0d want %0d", dut.state_q, ST_TLR);
    else pass_cnt++;
    total_cnt++;
    if ({OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN, inscanwrap_sel, outscanwrap_sel} !== 4'b0000)
      $display("FAIL tms_tlr_clear: got %b want 0000",
               {OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN, inscanwrap_sel, outscanwrap_sel});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_shift();
    logic [1:0] cap;
    load_ir(4'h4, cap);
    goto_shift_dr();
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    finish_dr();
    total_cnt++;
    if ({OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN} !== 2'b11)
      $display("FAIL pre_reset_en: got %b want 11", {OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN});
    else pass_cnt++;
    load_ir(4'h4, cap);
    goto_shift_dr();
    step(1'b0, 1'b0);
    TDR_TRESET = 1'b1;
    step(1'b0, 1'b0);
    TDR_TRESET = 1'b0;
    total_cnt++;
    if (dut.state_q !== ST_TLR) $display("FAIL mid_reset_state: got %0d want %0d", dut.state_q, ST_TLR);
    else pass_cnt++;
    total_cnt++;
    if ({OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN, TDO} !== 3'b000)
      $display("FAIL mid_reset_clear: got %b want 000", {OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN, TDO});
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0);
      total_cnt++;
      if ({TDR_UPDATE, OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN} !== 3'b000)
        $display("FAIL mid_reset_no_update%0d: got %b want 000", i,
                 {TDR_UPDATE, OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN});
      else pass_cnt++;
    end
  endtask

  task automatic test_bypass();
    logic [1:0] cap;
    logic [5:0] tdi_v, exp_v;
    tdi_v = 6'b00_1101;
    exp_v = 6'b01_1010;
    load_ir(4'h9, cap);
    total_cnt++;
    if ({inscanwrap_sel, outscanwrap_sel} !== 2'b00)
      $display("FAIL undef_sels: got %b want 00", {inscanwrap_sel, outscanwrap_sel});
    else pass_cnt++;
    goto_shift_dr();
    for (int i = 0; i < 6; i++) begin
      step(i == 5, tdi_v[i]);
      total_cnt++;
      if (TDO !== exp_v[i]) $display("FAIL bypass_bit%0d: got %b want %b", i, TDO, exp_v[i]);
      else pass_cnt++;
    end
    finish_dr();
  endtask

  initial begin
    TDR_TRESET = 1'b1; TMS = 1'b0; TDI = 1'b0; CTO = 1'b0;
    test_reset();
    test_default_ir();
    test_ir_capture();
    test_wrap_cfg();
    test_wrap_strobes();
    test_tlr_by_tms();
    test_reset_mid_shift();
    test_bypass();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tap_ctrl.md
TAP_CTRL -- requirements
Module: tap_ctrl

Interface
REQ-001 SHALL have parameter IR_W, default 4: instruction register width, minimum 3.
REQ-002 SHALL have parameter IDCODE_VAL, default 32'h1000_0A01: device ID; bit 0 forced to 1.
REQ-003 TDR_TCK  in  1  sole clock; all state changes on its rising edge.
REQ-004 TDR_TRESET  in  1  synchronous, active-high reset.
REQ-005 TMS  in  1  TAP mode select.
REQ-006 TDI  in  1  serial test data in.
REQ-007 CTO  in  1  scan-wrapper chain return.
REQ-008 TDO  out  1  serial test data out, registered.
REQ-009 CTI  out  1  scan-wrapper chain input, equals TDI.
REQ-010 TDR_CAPTURE, TDR_SHIFT, TDR_UPDATE  out  1 each  wrapper strobes.
REQ-011 INSCANWRAP_TDR_EN, OUTSCANWRAP_TDR_EN  out  1 each  wrapper enables from the WRAP_CFG register.
REQ-012 inscanwrap_sel, outscanwrap_sel  out  1 each  instruction decodes.

Function
REQ-013 SHALL implement the 16-state IEEE 1149.1 TAP FSM, advancing on TMS each rising edge.
REQ-014 Five consecutive TMS=1 cycles SHALL reach Test-Logic-Reset (TLR) from any state.
REQ-015 Capture-IR SHALL load IR shift register with {0..0,2'b01}; Shift-IR shifts LSB-first from TDI; Update-IR copies to active IR.
REQ-016 Opcodes: BYPASS=all ones, IDCODE=1, INSCANWRAP=2, OUTSCANWRAP=3, WRAP_CFG=4; all others SHALL decode as BYPASS.
REQ-017 BYPASS SHALL select a 1-bit register, captured to 0.
REQ-018 IDCODE SHALL select a 32-bit register, captured to IDCODE_VAL.
REQ-019 WRAP_CFG SHALL select a 2-bit shift register; Update-DR copies it to {OUTSCANWRAP_TDR_EN, INSCANWRAP_TDR_EN}.
REQ-020 inscanwrap_sel=1 iff active IR==INSCANWRAP; outscanwrap_sel=1 iff active IR==OUTSCANWRAP.
REQ-021 TDR_CAPTURE/TDR_SHIFT/TDR_UPDATE SHALL be high exactly while in Capture-DR/Shift-DR/Update-DR and either sel is high; else low.
REQ-022 When either sel is high, CTO SHALL be the DR path source for TDO.
REQ-023 TDO SHALL register the LSB of the selected IR/DR shift register on each Shift-IR/Shift-DR edge; 1-cycle latency; holds value outside Shift states.
REQ-024 Update-IR SHALL not alter WRAP_CFG outputs; Update-DR with WRAP_CFG inactive SHALL not alter them.
REQ-025 Entering TLR by TMS SHALL act as reset for IR and WRAP_CFG (REQ-027).

Reset
REQ-026 TDR_TRESET high at a rising edge SHALL force state=TLR, takes precedence over TMS.
REQ-027 Reset values: active IR=IDCODE (BYPASS if macro absent), WRAP_CFG=2'b00, TDO=0, all strobes and sels=0.
REQ-028 Reset asserted mid-Shift-DR SHALL abort the shift; no Update occurs; enables stay cleared.

Configuration
REQ-029 Macro TAP_CTRL_IDCODE_EN defined: IDCODE register and opcode present; reset IR=IDCODE.
REQ-030 Macro absent: no IDCODE register; opcode 1 decodes as BYPASS; reset IR=BYPASS.

Structure
REQ-031 Package tap_pkg SHALL hold TAP state enum, opcode constants and IR_W default.
REQ-032 FSM SHALL be sub-module tap_fsm (TMS, clock, reset in; state out); registers and muxing stay in tap_ctrl.

Verification
REQ-033 Reset, then shift 32 bits in Shift-DR with macro defined -> TDO yields 32'h1000_0A01 LSB-first, one cycle after each Shift edge.
REQ-034 Load IR=4, shift DR 2'b11, Update-DR -> both TDR_EN =1 at edge after Update-DR; IR=0xF then Update-DR -> unchanged.
REQ-035 Load IR=2, walk Capture/Shift x3/Update-DR -> TDR_CAPTURE 1 cycle, TDR_SHIFT 3 cycles, TDR_UPDATE 1 cycle; inscanwrap_sel=1; TDO follows CTO delayed one cycle.
REQ-036 From Shift-DR, TMS=1 for 5 cycles -> TLR; WRAP_CFG=00; sels=0.
REQ-037 TDR_TRESET pulsed during Shift-DR of WRAP_CFG -> state TLR next cycle; enables 00; no TDR_UPDATE pulse.
REQ-038 Load IR=0x9 (undefined) -> 1-bit bypass; TDI pattern 1011 appears on TDO delayed two cycles.
